// File: rtl/mem_stage_pkg.sv
// Shared types and widths for the MEM pipeline stage.
package mem_stage_pkg;

  localparam int unsigned WB_W   = 2;
  localparam int unsigned REG_AW = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory req/ack port between the MEM stage (master) and memory (slave).
interface mem_access_stage_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);

endinterface

// File: rtl/mem_timeout_ctr.sv
// Counts BUSY cycles without ack; expired flags the last allowed cycle.
module mem_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;

  assign expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Clear wins over increment; hold once expired so the count never wraps.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (inc && !expired) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: load/store over a variable-latency req/ack port, stalling upstream while busy.
// Optional BUSY timeout with sticky err_o is enabled by defining MEM_TIMEOUT_EN.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [WB_W-1:0]   WB_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [REG_AW-1:0] RDaddr_i,
  mem_access_stage_if.master mem_bus,
  output logic              stall_o,
  output logic [WB_W-1:0]   WB_o,
  output logic [DATA_W-1:0] data1_o,
  output logic [ADDR_W-1:0] data2_o,
  output logic [REG_AW-1:0] RDaddr_o,
  output logic              err_o
);

  state_e            state_q, state_d;
  logic              access;
  logic              launch;
  logic              capture;
  logic              req_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  assign access = MemRead_i | MemWrite_i;

`ifdef MEM_TIMEOUT_EN
  logic to_clear;
  logic to_inc;
  logic to_expired;
  logic abort;
  logic err_q;

  mem_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clear   (to_clear),
    .inc     (to_inc),
    .expired (to_expired)
  );
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and per-cycle control; DONE always returns to IDLE so a held request cannot re-issue.
  always_comb begin
    state_d = state_q;
    stall_o = 1'b0;
    launch  = 1'b0;
    capture = 1'b0;
`ifdef MEM_TIMEOUT_EN
    to_clear = 1'b0;
    to_inc   = 1'b0;
    abort    = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (access) begin
          stall_o = 1'b1;
          launch  = 1'b1;
          state_d = BUSY;
`ifdef MEM_TIMEOUT_EN
          to_clear = 1'b1;
`endif
        end
      end
      BUSY: begin
        stall_o = 1'b1;
        if (mem_bus.ack) begin
          capture = !we_q;
          state_d = DONE;
        end
`ifdef MEM_TIMEOUT_EN
        else if (to_expired) begin
          abort   = 1'b1;
          state_d = DONE;
        end else begin
          to_inc = 1'b1;
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request is live exactly while BUSY; address, data and direction latch at launch.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      req_q <= (state_d == BUSY);
      if (launch) begin
        we_q    <= MemWrite_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rdata_q <= '0;
    end else if (capture) begin
      rdata_q <= mem_bus.rdata;
    end
`ifdef MEM_TIMEOUT_EN
    else if (abort) begin
      rdata_q <= '0;
    end
`endif
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_q <= 1'b0;
    end else if (abort) begin
      err_q <= 1'b1;
    end
  end
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign mem_bus.req   = req_q;
  assign mem_bus.we    = we_q;
  assign mem_bus.addr  = addr_q;
  assign mem_bus.wdata = wdata_q;

  assign WB_o     = WB_i;
  assign data1_o  = rdata_q;
  assign data2_o  = addr_i;
  assign RDaddr_o = RDaddr_i;

endmodule
